// File: rtl/vector_issue_queue.sv
// Instruction FIFO between the host and the vector decoder: issues one legal
// instruction at a time, paced by per-opcode latency and exec_ready.
module vector_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int LS_LAT    = 2,
    parameter int MUL_LAT   = 3,
    parameter int FPADD_LAT = 4,
    parameter int FPMUL_LAT = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    input  logic [31:0]                push_data,
    output logic                       push_ready,
    input  logic                       exec_ready,
    input  logic                       flush,
    output logic [31:0]                instruction,
    output logic                       instruction_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       illegal_seen,
    output logic [15:0]                issued_count,
    output logic [1:0]                 fsm_state
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int MAX_AB  = (LS_LAT > MUL_LAT) ? LS_LAT : MUL_LAT;
    localparam int MAX_CD  = (FPADD_LAT > FPMUL_LAT) ? FPADD_LAT : FPMUL_LAT;
    localparam int MAX_LAT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int WW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Handshake: a push transfers on a rising edge where push_valid && push_ready;
    // an issue transfers on a rising edge where the head is legal and eligible
    // and exec_ready is high, and shows up as a one-cycle instruction_valid.

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q, count_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    state_t        state, state_nxt;

    logic [31:0] head;
    logic [4:0]  head_op;
    logic        full, empty, push_fire, head_ready, issue, discard, pop;

    function automatic logic [WW-1:0] lat_minus_one(input logic [4:0] op);
        int lat;
        case (op)
            5'b00000, 5'b00001: lat = LS_LAT;
            5'b00100, 5'b00101: lat = MUL_LAT;
            5'b00111, 5'b10000: lat = FPADD_LAT;
            5'b01000:           lat = FPMUL_LAT;
            default:            lat = 1;
        endcase
        return WW'(lat - 1);
    endfunction

    assign head       = mem[rd_ptr];
    assign head_op    = head[31:27];
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full && !flush;
    assign push_fire  = push_valid && push_ready;
    assign head_ready = !empty && (wait_cnt == '0) && !flush;
    assign issue      = head_ready && exec_ready && (head_op <= 5'b10000);
    // Illegal heads are dropped without waiting for the datapath.
    assign discard    = head_ready && (head_op > 5'b10000);
    assign pop        = issue || discard;

    assign count     = count_q;
    assign busy      = (count_q != '0) || (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        count_nxt = count_q;
        if (push_fire && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (!push_fire && pop) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_comb begin
        wait_nxt = '0;
        if (issue) begin
            wait_nxt = lat_minus_one(head_op);
        end else if (wait_cnt != '0) begin
            wait_nxt = wait_cnt - WW'(1);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (flush) begin
            state_nxt = IDLE;
        end else if (wait_nxt != '0) begin
            state_nxt = WAIT;
        end else if (count_nxt != '0) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count_q           <= '0;
            wait_cnt          <= '0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            illegal_seen      <= 1'b0;
            issued_count      <= '0;
        end else if (flush) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count_q           <= '0;
            wait_cnt          <= '0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            illegal_seen      <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            wait_cnt <= wait_nxt;
            if (push_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (discard) begin
                illegal_seen <= 1'b1;
            end
            if (issue) begin
                instruction       <= head;
                instruction_valid <= 1'b1;
                issued_count      <= issued_count + 16'd1;
            end else begin
                instruction       <= '0;
                instruction_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Self-checking bench for vector_issue_queue: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_vector_issue_queue;

    localparam int DEPTH     = 8;
    localparam int LS_LAT    = 2;
    localparam int MUL_LAT   = 3;
    localparam int FPADD_LAT = 4;
    localparam int FPMUL_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_ready;
    logic        exec_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic [3:0]  count;
    logic        busy;
    logic        illegal_seen;
    logic [15:0] issued_count;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    vector_issue_queue #(
        .DEPTH(DEPTH), .LS_LAT(LS_LAT), .MUL_LAT(MUL_LAT),
        .FPADD_LAT(FPADD_LAT), .FPMUL_LAT(FPMUL_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .exec_ready(exec_ready), .flush(flush),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .count(count), .busy(busy), .illegal_seen(illegal_seen),
        .issued_count(issued_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pd, input logic er, input logic fl);
        push_valid = pv;
        push_data  = pd;
        exec_ready = er;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue spacing straight from the opcode classes.
    function automatic int spacing(input logic [4:0] op);
        case (op)
            5'd0, 5'd1:  return LS_LAT;
            5'd4, 5'd5:  return MUL_LAT;
            5'd7, 5'd16: return FPADD_LAT;
            5'd8:        return FPMUL_LAT;
            default:     return 1;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        logic [4:0]  op;
        logic [26:0] low;
        if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(17, 31));
        else                            op = 5'($urandom_range(0, 16));
        low = 27'($urandom);
        return {op, low};
    endfunction

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        er;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [3:0]  e_count;
        logic        e_pready;
        logic        e_busy;
        logic [15:0] e_issued;
    } vec_t;

    vec_t tbl[11];

    logic [31:0] exp_q[$];

    // Reference model state
    logic [31:0] m_q[$];
    longint      m_cyc;
    longint      m_next_ok;
    logic        m_ill;
    logic [15:0] m_iss;
    logic        m_valid;
    logic [31:0] m_instr;

    task automatic async_reset();
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_issued;
        int rcv;
        int pushed;
        int pulse_cyc[$];
        logic [31:0] pulse_dat[$];

        // c0: push VADD; c1: queued; c2: pulse; then VMUL followed by VADD.
        tbl[0]  = '{1, 32'h1000_0000, 1, 0, 0, 32'h0,         0, 1, 0, 0};
        tbl[1]  = '{0, 32'h0,         1, 0, 0, 32'h0,         1, 1, 1, 0};
        tbl[2]  = '{0, 32'h0,         1, 0, 1, 32'h1000_0000, 0, 1, 0, 1};
        tbl[3]  = '{0, 32'h0,         1, 0, 0, 32'h0,         0, 1, 0, 1};
        tbl[4]  = '{1, 32'h2000_0000, 1, 0, 0, 32'h0,         0, 1, 0, 1};
        tbl[5]  = '{1, 32'h1000_0001, 1, 0, 0, 32'h0,         1, 1, 1, 1};
        tbl[6]  = '{0, 32'h0,         1, 0, 1, 32'h2000_0000, 1, 1, 1, 2};
        tbl[7]  = '{0, 32'h0,         1, 0, 0, 32'h0,         1, 1, 1, 2};
        tbl[8]  = '{0, 32'h0,         1, 0, 0, 32'h0,         1, 1, 1, 2};
        tbl[9]  = '{0, 32'h0,         1, 0, 1, 32'h1000_0001, 0, 1, 0, 3};
        tbl[10] = '{0, 32'h0,         1, 0, 0, 32'h0,         0, 1, 0, 3};

        // Reset state
        #2;
        chk("reset_valid", 32'(instruction_valid), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_issued", 32'(issued_count), 0);
        async_reset();
        @(negedge clk);
        chk("post_reset_push_ready", 32'(push_ready), 1);
        chk("post_reset_state", 32'(fsm_state), 0);
        tick();

        // Directed table: single op and latency pacing
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pv, tbl[i].pd, tbl[i].er, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(instruction_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].e_instr);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_push_ready", i), 32'(push_ready), 32'(tbl[i].e_pready));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_issued", i), 32'(issued_count), 32'(tbl[i].e_issued));
            tick();
        end
        exp_issued = 3;

        // Full and wrap: fill with exec_ready low, ninth push refused
        for (int i = 0; i < 9; i++) begin
            drive(1, 32'h1000_0100 + 32'(i), 0, 0);
            @(negedge clk);
            if (i == 8) begin
                chk("full_count", 32'(count), 8);
                chk("full_push_ready", 32'(push_ready), 0);
            end else begin
                chk("fill_count", 32'(count), 32'(i));
                exp_q.push_back(32'h1000_0100 + 32'(i));
            end
            tick();
        end
        rcv = 0;
        pushed = 0;
        for (int c = 0; c < 60 && rcv < 16; c++) begin
            if (c >= 1 && pushed < 8) drive(1, 32'h1000_0200 + 32'(pushed), 1, 0);
            else                      drive(0, 32'h0, 1, 0);
            @(negedge clk);
            if (c == 0) chk("wrap_still_full", 32'(count), 8);
            if (push_valid) begin
                chk("wrap_push_ready", 32'(push_ready), 1);
                exp_q.push_back(push_data);
                pushed++;
            end
            if (instruction_valid) begin
                if (exp_q.size() == 0) chk("wrap_extra_issue", instruction, 32'hxxxx_xxxx);
                else                   chk("wrap_order", instruction, exp_q.pop_front());
                rcv++;
            end
            tick();
        end
        chk("wrap_all_issued", 32'(rcv), 16);
        exp_issued += 16;
        drive(0, 32'h0, 1, 0);
        tick();

        // Illegal opcode between two VANDs
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       drive(1, 32'h1800_0001, 1, 0);
                1:       drive(1, 32'hF800_0000, 1, 0);
                2:       drive(1, 32'h1800_0002, 1, 0);
                default: drive(0, 32'h0, 1, 0);
            endcase
            @(negedge clk);
            if (instruction_valid) begin
                pulse_cyc.push_back(c);
                pulse_dat.push_back(instruction);
            end
            tick();
        end
        chk("illegal_pulse_count", 32'(pulse_cyc.size()), 2);
        if (pulse_cyc.size() == 2) begin
            chk("illegal_first_cycle", 32'(pulse_cyc[0]), 2);
            chk("illegal_second_cycle", 32'(pulse_cyc[1]), 4);
            chk("illegal_first_data", pulse_dat[0], 32'h1800_0001);
            chk("illegal_second_data", pulse_dat[1], 32'h1800_0002);
        end
        chk("illegal_seen", 32'(illegal_seen), 1);
        exp_issued += 2;
        chk("illegal_issued", 32'(issued_count), 32'(exp_issued));

        // Flush mid-WAIT after VFMUL with three queued ops
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       drive(1, 32'h4000_0000, 1, 0);
                1:       drive(1, 32'h1000_0301, 1, 0);
                2:       drive(1, 32'h1000_0302, 1, 0);
                3:       drive(1, 32'h1000_0303, 1, 0);
                4:       drive(0, 32'h0, 1, 1);
                5:       drive(1, 32'h1000_0400, 1, 0);
                default: drive(0, 32'h0, 1, 0);
            endcase
            @(negedge clk);
            case (c)
                2: chk("flush_vfmul_pulse", instruction, 32'h4000_0000);
                4: begin
                    chk("flush_pre_state_wait", 32'(fsm_state), 2);
                    chk("flush_pre_count", 32'(count), 3);
                    chk("flush_push_ready", 32'(push_ready), 0);
                end
                5: begin
                    chk("flush_count", 32'(count), 0);
                    chk("flush_state_idle", 32'(fsm_state), 0);
                    chk("flush_illegal_cleared", 32'(illegal_seen), 0);
                    chk("flush_issued_kept", 32'(issued_count), 32'(exp_issued + 1));
                    chk("flush_valid", 32'(instruction_valid), 0);
                    chk("flush_busy", 32'(busy), 0);
                end
                6: begin
                    chk("flush_new_count", 32'(count), 1);
                    chk("flush_new_not_yet", 32'(instruction_valid), 0);
                end
                7: begin
                    chk("flush_new_valid", 32'(instruction_valid), 1);
                    chk("flush_new_instr", instruction, 32'h1000_0400);
                end
                default: ;
            endcase
            tick();
        end

        // Asynchronous reset in the middle of an issue pulse
        drive(1, 32'h1000_0500, 1, 0);
        tick();
        drive(1, 32'h1000_0501, 1, 0);
        tick();
        drive(0, 32'h0, 1, 0);
        #1;
        chk("areset_pulse_before", 32'(instruction_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 32'(instruction_valid), 0);
        chk("areset_instr", instruction, 0);
        chk("areset_count", 32'(count), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_issued", 32'(issued_count), 0);
        chk("areset_illegal", 32'(illegal_seen), 0);
        chk("areset_state", 32'(fsm_state), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("areset_push_ready", 32'(push_ready), 1);
        chk("areset_empty", 32'(count), 0);
        tick();

        // Randomized traffic against the reference model
        m_q.delete();
        m_cyc = 0;
        m_next_ok = 0;
        m_ill = 1'b0;
        m_iss = '0;
        m_valid = 1'b0;
        m_instr = '0;
        for (int n = 0; n < 1500; n++) begin
            logic        pv, er, fl;
            logic [31:0] pd;
            int          sz;
            pv = ($urandom_range(0, 9) < 7);
            pd = rand_word();
            er = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            drive(pv, pd, er, fl);
            @(negedge clk);
            sz = m_q.size();
            chk("rnd_valid", 32'(instruction_valid), 32'(m_valid));
            chk("rnd_instr", instruction, m_instr);
            chk("rnd_count", 32'(count), 32'(sz));
            chk("rnd_push_ready", 32'(push_ready), 32'((sz < DEPTH) && !fl));
            chk("rnd_busy", 32'(busy), 32'((sz != 0) || (m_cyc < m_next_ok)));
            chk("rnd_illegal", 32'(illegal_seen), 32'(m_ill));
            chk("rnd_issued", 32'(issued_count), 32'(m_iss));
            m_valid = 1'b0;
            m_instr = '0;
            if (fl) begin
                m_q.delete();
                m_next_ok = 0;
                m_ill = 1'b0;
            end else begin
                if (sz > 0 && m_cyc >= m_next_ok) begin
                    if (m_q[0][31:27] > 5'd16) begin
                        void'(m_q.pop_front());
                        m_ill = 1'b1;
                    end else if (er) begin
                        m_instr = m_q.pop_front();
                        m_valid = 1'b1;
                        m_next_ok = m_cyc + longint'(spacing(m_instr[31:27]));
                        m_iss = m_iss + 16'd1;
                    end
                end
                if (pv && sz < DEPTH) m_q.push_back(pd);
            end
            m_cyc++;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
